// File: rtl/restoring_divider.sv
// restoring_divider: fixed-latency unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sh, w_diff;
  logic [WIDTH-1:0] w_rem, w_quo;
  // r_a shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_sh   = {r_rem, r_a[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_rem  = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo  = {r_a[WIDTH-2:0], ~w_diff[WIDTH]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && r_state != RUN) begin
        r_state <= RUN;
        r_a     <= a;
        r_b     <= b;
        r_rem   <= '0;
        r_cnt   <= '0;
        busy    <= 1'b1;
      end else if (r_state == RUN && r_b == '0) begin
        r_state <= FIN;
        q       <= '1;
        r       <= r_a;
        dz      <= 1'b1;
        done    <= 1'b1;
        busy    <= 1'b0;
      end else if (r_state == RUN) begin
        r_a   <= w_quo;
        r_rem <= w_rem;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_state <= FIN;
          q       <= w_quo;
          r       <= w_rem;
          dz      <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end else if (r_state == FIN) begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and random scoreboard bench for restoring_divider
module tb_restoring_divider;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, q, r;
  logic busy, done, dz;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {
    bit           ident;
    logic [W-1:0] a, b, q, r;
    bit           dz;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done q=%0h r=%0h at cycle %0d", q, r, cyc);
      end else begin
        m_e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(m_e.cyc));
        if (m_e.ident) begin
          chk("identity", 64'(q) * 64'(m_e.b) + 64'(r), 64'(m_e.a));
          chk("r_lt_b", 64'(r < m_e.b), 64'd1);
        end else begin
          chk("q", 64'(q), 64'(m_e.q));
          chk("r", 64'(r), 64'(m_e.r));
        end
        chk("dz", 64'(dz), 64'(m_e.dz));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit ident,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
    exp_t e;
    a = ta;
    b = tb_;
    start = 1'b1;
    e.ident = ident;
    e.a = ta;
    e.b = tb_;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.cyc = cyc + 1 + ((tb_ == '0) ? 1 : W);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for done at cycle %0d", cyc);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_q"}, 64'(q), 64'd0);
    chk({n, "_r"}, 64'(r), 64'd0);
    chk({n, "_busy"}, 64'(busy), 64'd0);
    chk({n, "_done"}, 64'(done), 64'd0);
    chk({n, "_dz"}, 64'(dz), 64'd0);
  endtask

  initial begin
    int bc;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    issue(3, 3, 0, 1, 0, 0);
    wait_done(bc);
    chk("busy_cycles", 64'(bc), 64'd32);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    issue(100, 7, 0, 14, 2, 0);
    wait_done(bc);
    issue(3, 5, 0, 0, 3, 0);
    wait_done(bc);
    @(negedge clk);
    issue('1, 1, 0, '1, 0, 0);
    wait_done(bc);
    issue('1, '1, 0, 1, 0, 0);
    wait_done(bc);
    @(negedge clk);
    issue(5, 0, 0, '1, 5, 1);
    wait_done(bc);
    chk("dz_busy_cycles", 64'(bc), 64'd1);
    @(negedge clk);
    issue(10, 3, 0, 3, 1, 0);
    wait_done(bc);
    @(negedge clk);
    issue(9, 3, 0, 3, 0, 0);
    repeat (8) @(negedge clk);
    a = 50;
    b = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    repeat (3) @(negedge clk);
    a = 77;
    b = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("abort");
    repeat (40) @(negedge clk);
    issue(21, 4, 0, 5, 1, 0);
    wait_done(bc);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 1;
      if (i % 7 == 0) ra = ra >> $urandom_range(0, 31);
      issue(ra, rb, 1, '0, '0, 0);
      wait_done(bc);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only on rising edges.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned dividend.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned divisor.
REQ-007 The block SHALL have port q, output, WIDTH bits: quotient, registered.
REQ-008 The block SHALL have port r, output, WIDTH bits: remainder, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when q and r become valid.
REQ-011 The block SHALL have port dz, output, 1 bit: divide-by-zero flag for the most recent completed operation.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-013 The block SHALL accept start only in IDLE or FIN. On the accepting edge it captures a and b into internal registers, sets busy=1 and enters RUN.
REQ-014 The block SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 The block SHALL, in RUN, perform one restoring step per clock:
- shift partial remainder left by 1, bringing in the next dividend MSB;
- trial-subtract the divisor using a WIDTH+1-bit subtractor;
- if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-016 The block SHALL use a log2(WIDTH)+1-bit iteration counter. After exactly WIDTH steps it enters FIN, loads q and r, pulses done=1 for one cycle, clears busy and clears dz.
REQ-017 Latency SHALL be fixed: with start accepted at edge N, done is high during the cycle following edge N+WIDTH (32 cycles later for WIDTH=32). Latency is independent of operand values.
REQ-018 For a captured divisor of 0, the block SHALL skip RUN. It goes to FIN at the next edge with q=all ones, r=captured a, dz=1, done pulsed and busy=0 (latency 1 cycle).
REQ-019 The block SHALL hold q, r and dz unchanged from completion until the next completion. They SHALL NOT change during RUN.
REQ-020 FIN SHALL return to IDLE on the next edge unless start is high, in which case a new operation is accepted (back-to-back operation, no idle gap).
REQ-021 Results SHALL satisfy a = q*b + r with r < b, unsigned, for every b != 0. This includes a < b (q=0, r=a) and a=0 (q=0, r=0).
REQ-022 Operand inputs a and b SHALL be don't-care except on the accepting edge.

Reset
REQ-023 On any edge with rst=1, the block SHALL enter IDLE with q=0, r=0, busy=0, done=0, dz=0, counter=0 and internal registers cleared.
REQ-024 rst SHALL take priority over start. An operation in RUN SHALL be aborted with no done pulse.
REQ-025 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- a=3, b=3, start for 1 cycle -> done at start edge +32; q=1, r=0, dz=0; busy high for exactly 32 cycles.
- a=100, b=7 -> q=14, r=2. Then a=3, b=5 back-to-back from FIN -> q=0, r=3, with no idle cycle between.
- a=32'hFFFFFFFF, b=1 -> q=32'hFFFFFFFF, r=0. Then a=32'hFFFFFFFF, b=32'hFFFFFFFF -> q=1, r=0.
- a=5, b=0 -> done 1 cycle after start; q=32'hFFFFFFFF, r=5, dz=1. The next valid operation clears dz.
- start with a=9, b=3, then start again with a=50, b=5 at cycle 10 (ignored) -> q=3, r=0, with a single done pulse.
- rst asserted at cycle 15 of a run -> all outputs 0, no done pulse. A subsequent a=21, b=4 -> q=5, r=1.
- Random unsigned operand sweep (>=1000 vectors) against the identity a = q*b + r with r < b.
